// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: message sequencer feeding the seven-segment shift buffer.
// Plays stored symbol codes at a fixed step rate, then loops or flushes blanks.
module hex_scroll_ctrl #(
   parameter int         MSG_LEN  = 8,
   parameter int         TICK_DIV = 4,
   parameter int         WIDTH    = 5,
   parameter logic [4:0] BLANK    = 5'd31,
   localparam int        LW = $clog2(MSG_LEN + 1),
   localparam int        AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic          pause,
   input  logic          loop_en,
   input  logic [LW-1:0] msg_len,
   input  logic          msg_wr,
   input  logic [AW-1:0] msg_addr,
   input  logic [4:0]    msg_data,
   output logic [4:0]    sym,
   output logic          ex,
   output logic          busy,
   output logic          done
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int FW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [LW-1:0] len_q, len_d;
   logic [4:0]    sym_q, sym_d;
   logic          ex_q, ex_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [4:0]    mem_q [MSG_LEN];

   logic          addr_ok;
   logic          wr_ok;
   logic          idle_like;
   logic          active;
   logic          tick_last;
   logic          idx_last;
   logic          fcnt_last;
   logic [LW-1:0] len_new;

   // Out-of-range addresses only exist when the depth is not a power of two.
   if (MSG_LEN == (1 << AW)) begin : g_addr_full
      assign addr_ok = 1'b1;
   end else begin : g_addr_part
      assign addr_ok = (msg_addr < AW'(MSG_LEN));
   end

   assign idle_like = (state_q == IDLE) || (state_q == DONE);
   assign active    = (state_q == RUN) || (state_q == FLUSH);
   assign wr_ok     = msg_wr && addr_ok && idle_like;

   assign tick_last = (tick_q == TW'(TICK_DIV - 1));
   assign idx_last  = (int'(idx_q) == int'(len_q) - 1);
   assign fcnt_last = (fcnt_q == FW'(WIDTH - 1));

   assign len_new = (msg_len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len;

   // Message memory: cleared to blanks on reset, writable only when not playing.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MSG_LEN; i++) begin
            mem_q[i] <= BLANK;
         end
      end else if (wr_ok) begin
         mem_q[msg_addr] <= msg_data;
      end
   end

   // Next-state logic: stop beats start, start beats pause, pause beats stepping.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      idx_d   = idx_q;
      fcnt_d  = fcnt_q;
      len_d   = len_q;
      sym_d   = sym_q;
      ex_d    = 1'b0;

      if (stop) begin
         state_d = IDLE;
         sym_d   = BLANK;
         tick_d  = '0;
         idx_d   = '0;
         fcnt_d  = '0;
      end else if (start && idle_like) begin
         len_d   = len_new;
         tick_d  = '0;
         idx_d   = '0;
         fcnt_d  = '0;
         state_d = (len_new == '0) ? FLUSH : RUN;
      end else if (active && !pause) begin
         if (!tick_last) begin
            tick_d = tick_q + TW'(1);
         end else begin
            tick_d = '0;
            ex_d   = 1'b1;
            if (state_q == RUN) begin
               sym_d = mem_q[idx_q];
               if (!idx_last) begin
                  idx_d = idx_q + AW'(1);
               end else if (loop_en) begin
                  idx_d = '0;
               end else begin
                  fcnt_d  = '0;
                  state_d = FLUSH;
               end
            end else begin
               sym_d  = BLANK;
               fcnt_d = fcnt_q + FW'(1);
               if (fcnt_last) begin
                  state_d = DONE;
               end
            end
         end
      end

      busy_d = (state_d == RUN) || (state_d == FLUSH);
      done_d = (state_d == DONE);
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         idx_q   <= '0;
         fcnt_q  <= '0;
         len_q   <= '0;
         sym_q   <= BLANK;
         ex_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         idx_q   <= idx_d;
         fcnt_q  <= fcnt_d;
         len_q   <= len_d;
         sym_q   <= sym_d;
         ex_q    <= ex_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sym  = sym_q;
   assign ex   = ex_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
